// File: rtl/skid_buffer_pkg.sv
// skid_buffer_pkg
// Shared definitions for the two-entry skid buffer: the control state type
// and the default word width.
package skid_buffer_pkg;

    // EMPTY: no entry valid; BUSY: main entry only; FULL: main and skid.
    typedef enum logic [1:0] {
        SKB_EMPTY = 2'd0,
        SKB_BUSY  = 2'd1,
        SKB_FULL  = 2'd2
    } skb_state_t;

    localparam int SKB_DEFAULT_LENGTH = 4;

endpackage : skid_buffer_pkg

// File: rtl/skid_data_reg.sv
// skid_data_reg
// LENGTH-wide data register with synchronous load enable and asynchronous
// active-low clear to zero. Holds its value whenever load is low, so an
// invalid entry simply keeps stale data.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low clear (0 = clear)
//   load   in   capture d on the next rising edge
//   d      in   LENGTH-bit word to capture
//   q      out  LENGTH-bit stored word
module skid_data_reg
    import skid_buffer_pkg::*;
#(
    parameter int LENGTH = SKB_DEFAULT_LENGTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LENGTH-1:0] d,
    output logic [LENGTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : skid_data_reg

// File: rtl/skid_buffer_l4.sv
// skid_buffer_l4
// Two-entry valid/ready pipeline register (skid buffer). A word arriving
// while the consumer stalls is parked in the skid entry, so in_ready can be
// a plain flop with no combinational path from out_ready while one word per
// cycle still flows when the consumer is ready.
//
// Handshake: a word moves on a rising edge when valid and ready are both
// high on that interface; a producer holds valid/data until it is taken, and
// out_data is stable while out_valid=1 and out_ready=0.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset (0 = reset)
//   in_valid   in   upstream word present
//   in_data    in   upstream word (LENGTH bits)
//   in_ready   out  buffer accepts a word this cycle (registered)
//   out_valid  out  downstream word present (registered)
//   out_data   out  downstream word (LENGTH bits)
//   out_ready  in   downstream accepts this cycle
//   dbg_state  out  current control state (skb_state_t encoding)
//   flush      in   only with SKID_BUFFER_FLUSH_EN: squash both entries
//
// Optional feature macro: SKID_BUFFER_FLUSH_EN adds the flush input.
module skid_buffer_l4
    import skid_buffer_pkg::*;
#(
    parameter int LENGTH = SKB_DEFAULT_LENGTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [LENGTH-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [LENGTH-1:0] out_data,
    input  logic              out_ready,
`ifdef SKID_BUFFER_FLUSH_EN
    input  logic              flush,
`endif
    output logic [1:0]        dbg_state
);

    skb_state_t        state;
    skb_state_t        state_nxt;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              in_xfer;
    logic              out_xfer;
    logic              main_load;
    logic              skid_load;
    logic              main_from_skid;
    logic [LENGTH-1:0] main_d;
    logic [LENGTH-1:0] main_q;
    logic [LENGTH-1:0] skid_q;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Next state and data-register load enables.
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            SKB_EMPTY: begin
                if (in_xfer) begin
                    main_load = 1'b1;
                    state_nxt = SKB_BUSY;
                end
            end
            SKB_BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (in_xfer) begin
                    skid_load = 1'b1;
                    state_nxt = SKB_FULL;
                end else if (out_xfer) begin
                    state_nxt = SKB_EMPTY;
                end
            end
            SKB_FULL: begin
                // in_ready is low here, so only the drain path can fire.
                if (out_xfer) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = SKB_BUSY;
                end
            end
            default: begin
                // Unused encoding (skid without main): drop back to EMPTY.
                state_nxt = SKB_EMPTY;
            end
        endcase
`ifdef SKID_BUFFER_FLUSH_EN
        // Squash wins over any transfer in the same cycle; nothing is captured.
        if (flush) begin
            state_nxt      = SKB_EMPTY;
            main_load      = 1'b0;
            skid_load      = 1'b0;
            main_from_skid = 1'b0;
        end
`endif
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SKB_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state       <= state_nxt;
            out_valid_q <= (state_nxt != SKB_EMPTY);
            in_ready_q  <= (state_nxt != SKB_FULL);
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    skid_data_reg #(.LENGTH(LENGTH)) u_main_reg (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    skid_data_reg #(.LENGTH(LENGTH)) u_skid_reg (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign dbg_state = state;

endmodule : skid_buffer_l4

// File: tb/tb_skid_buffer_l4.sv
// tb_skid_buffer_l4
// Self-checking bench for skid_buffer_l4. A queue model of a two-deep FIFO
// predicts out_valid/out_data/in_ready every cycle; directed steps add
// hand-computed literal expectations.
module tb_skid_buffer_l4;
    import skid_buffer_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         flush;
    logic [1:0]   dbg_state;

    int vectors;
    int miscompares;

    logic [W-1:0] exp_q[$];

    skid_buffer_l4 #(.LENGTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
`ifdef SKID_BUFFER_FLUSH_EN
        .flush     (flush),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of capacity two. in_ready reflects the occupancy at the
    // start of the cycle, so a pop in the same cycle does not open a slot.
    always @(posedge clk) begin
        if (reset) begin
            int  size_now;
            logic acc_in;
            logic acc_out;
            size_now = exp_q.size();
            acc_in   = in_valid && (size_now < 2);
            acc_out  = (size_now > 0) && out_ready;
            if (acc_out) void'(exp_q.pop_front());
            if (acc_in) exp_q.push_back(in_data);
`ifdef SKID_BUFFER_FLUSH_EN
            if (flush) exp_q.delete();
`endif
        end
    end

    always @(negedge reset) exp_q.delete();

    // Compare process: every falling edge.
    always @(negedge clk) begin
        chk("model_out_valid", {7'd0, out_valid}, {7'd0, exp_q.size() > 0});
        chk("model_in_ready", {7'd0, in_ready}, {7'd0, exp_q.size() < 2});
        if (exp_q.size() > 0)
            chk("model_out_data", {4'd0, out_data}, {4'd0, exp_q[0]});
    end

    // ---------------- driver ----------------
    // Inputs change just after a falling edge; returns just after the next
    // falling edge, when the post-edge outputs are settled.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Directed table: {in_valid, in_data, out_ready}.
    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
    } vec_t;

    vec_t tbl[10];

    initial begin
        vectors     = 0;
        miscompares = 0;
        flush       = 1'b0;
        in_valid    = 1'b1;
        in_data     = 4'hA;
        out_ready   = 1'b0;
        reset       = 1'b0;

        // ---- reset ----
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_out_data", {4'd0, out_data}, 8'd0);
        chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
        reset = 1'b1;
        step(1'b1, 4'hA, 1'b0);
        chk("rst_first_valid", {7'd0, out_valid}, 8'd1);
        chk("rst_first_data", {4'd0, out_data}, 8'h0A);
        step(1'b0, 4'h0, 1'b1);
        chk("rst_drain", {7'd0, out_valid}, 8'd0);

        // ---- streaming ----
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 4'(i), 1'b1);
            chk("stream_data", {4'd0, out_data}, 8'(i));
            chk("stream_in_ready", {7'd0, in_ready}, 8'd1);
        end
        step(1'b0, 4'h0, 1'b1);
        chk("stream_empty", {7'd0, out_valid}, 8'd0);

        // ---- backpressure ----
        step(1'b1, 4'h5, 1'b0);
        chk("bp_first", {4'd0, out_data}, 8'h05);
        step(1'b1, 4'h6, 1'b0);
        chk("bp_full_ready", {7'd0, in_ready}, 8'd0);
        chk("bp_hold5", {4'd0, out_data}, 8'h05);
        step(1'b1, 4'h7, 1'b0);
        chk("bp_reject7_ready", {7'd0, in_ready}, 8'd0);
        chk("bp_still5", {4'd0, out_data}, 8'h05);
        step(1'b1, 4'h7, 1'b1);
        chk("bp_out6", {4'd0, out_data}, 8'h06);
        chk("bp_ready_back", {7'd0, in_ready}, 8'd1);
        step(1'b1, 4'h7, 1'b1);
        chk("bp_out7", {4'd0, out_data}, 8'h07);
        step(1'b0, 4'h0, 1'b1);
        chk("bp_empty", {7'd0, out_valid}, 8'd0);

        // ---- simultaneous in/out while BUSY ----
        step(1'b1, 4'h8, 1'b0);
        chk("sim_main8", {4'd0, out_data}, 8'h08);
        step(1'b1, 4'h9, 1'b1);
        chk("sim_out9", {4'd0, out_data}, 8'h09);
        chk("sim_in_ready", {7'd0, in_ready}, 8'd1);
        chk("sim_state_busy", {6'd0, dbg_state}, {6'd0, SKB_BUSY});
        step(1'b0, 4'h0, 1'b1);

        // ---- mid-operation asynchronous reset ----
        step(1'b1, 4'hB, 1'b0);
        step(1'b1, 4'hC, 1'b0);
        chk("mid_full", {7'd0, in_ready}, 8'd0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid_async_valid", {7'd0, out_valid}, 8'd0);
        chk("mid_async_ready", {7'd0, in_ready}, 8'd1);
        @(negedge clk); #1;
        reset = 1'b1;
        step(1'b0, 4'h0, 1'b1);
        chk("mid_no_B", {7'd0, out_valid}, 8'd0);
        step(1'b0, 4'h0, 1'b1);
        chk("mid_no_C", {7'd0, out_valid}, 8'd0);

`ifdef SKID_BUFFER_FLUSH_EN
        // ---- flush ----
        step(1'b1, 4'h1, 1'b0);
        step(1'b1, 4'h2, 1'b0);
        chk("fl_full", {7'd0, in_ready}, 8'd0);
        flush = 1'b1;
        step(1'b1, 4'hD, 1'b0);
        flush = 1'b0;
        chk("fl_out_valid", {7'd0, out_valid}, 8'd0);
        chk("fl_in_ready", {7'd0, in_ready}, 8'd1);
        step(1'b0, 4'h0, 1'b1);
        chk("fl_no_D", {7'd0, out_valid}, 8'd0);
`endif

        // ---- mixed directed table (checked by the model) ----
        tbl[0] = '{1'b1, 4'h3, 1'b0};
        tbl[1] = '{1'b1, 4'hE, 1'b0};
        tbl[2] = '{1'b1, 4'hF, 1'b1};
        tbl[3] = '{1'b0, 4'h0, 1'b0};
        tbl[4] = '{1'b1, 4'h1, 1'b1};
        tbl[5] = '{1'b1, 4'h6, 1'b1};
        tbl[6] = '{1'b0, 4'h0, 1'b1};
        tbl[7] = '{1'b1, 4'h2, 1'b0};
        tbl[8] = '{1'b0, 4'h0, 1'b1};
        tbl[9] = '{1'b0, 4'h0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r);
        end
        // After the table every word has drained.
        chk("tbl_drained", {7'd0, out_valid}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_skid_buffer_l4

// File: doc/skid_buffer_l4.md
Name: skid_buffer_l4

Overview:
- Two-entry valid/ready pipeline register (skid buffer) for the out-of-order datapath.
- Where a plain enabled register wall is written only when an external enable is asserted, this block generates that enable itself as upstream back-pressure (in_ready).
- It also hands data downstream under a valid/ready handshake.
- Sits between rename/dispatch stages so a stalled consumer never drops an in-flight word, while sustaining one transfer per cycle.

Parameters:
- LENGTH, 4, data width in bits of each buffered word.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset: 0 = reset.
- in_valid  input  1  upstream word present.
- in_data  input  LENGTH  upstream word.
- in_ready  output  1  block can accept a word this cycle.
- out_valid  output  1  downstream word present.
- out_data  output  LENGTH  downstream word.
- out_ready  input  1  downstream accepts this cycle.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - All state changes on rising clk.
- Storage: main entry (main_valid, main_data) and skid entry (skid_valid, skid_data).
- Output mapping: out_valid = main_valid; out_data = main_data; in_ready = ~skid_valid, driven straight from a flop with no combinational path from out_ready.
- Reset (reset=0, asynchronous): main_valid=0, skid_valid=0, main_data=0, skid_data=0. Therefore out_valid=0, out_data=0, in_ready=1.
- States: EMPTY (neither valid), BUSY (main only), FULL (main and skid).
- EMPTY:
  - Input transfer -> main <= in_data, go BUSY.
  - Otherwise stay EMPTY.
  - out_ready is ignored.
- BUSY:
  - Input and output transfer -> main <= in_data, stay BUSY.
  - Input only -> skid <= in_data, go FULL.
  - Output only -> go EMPTY.
  - Neither -> hold.
- FULL (in_ready=0):
  - Output transfer -> main <= skid_data, skid cleared, go BUSY.
  - Otherwise hold.
  - in_valid is ignored.
- Latency: a word accepted in cycle N is visible on out_valid/out_data in cycle N+1 when EMPTY at N.
- Throughput: one word per cycle while out_ready=1.
- Ordering: strict FIFO order; no word is dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_data holds unchanged.
- Data registers load only when their entry is written. Invalid entries retain stale data; only the reset value is guaranteed 0.
- State encoding: the invalid state (skid valid, main invalid) is unreachable. If forced, it recovers to EMPTY on the next edge.
- Reset mid-operation: both entries are discarded immediately and asynchronously. The first edge after reset deasserts behaves as EMPTY.

Optional Feature:
- Macro: SKID_BUFFER_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush=1 at a rising edge forces EMPTY (both valids 0) regardless of any transfers that cycle. Incoming in_data is not captured.
  - in_ready=1 the cycle after.
  - Data registers are not required to clear.
  - Used for mispredict squash.
- Undefined: no flush port; behaviour exactly as above.

Decomposition:
- Shared package skid_buffer_pkg:
  - typedef enum logic [1:0] {SKB_EMPTY, SKB_BUSY, SKB_FULL} skb_state_t.
  - Constant SKB_DEFAULT_LENGTH = 4.
- Sub-module skid_data_reg: LENGTH-wide register with synchronous load enable and asynchronous active-low clear to 0.
  - Instantiated twice, once each for main_data and skid_data.
  - Control FSM stays in the top.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 with in_valid=1, in_data=4'hA, then release.
  - Required during reset: out_valid=0, out_data=0, in_ready=1.
  - Required on the first edge after release: word 4'hA accepted; out_valid=1 and out_data=4'hA next cycle.
- Streaming:
  - Stimulus: out_ready=1, feed 4'h1,4'h2,4'h3,4'h4 on consecutive cycles.
  - Required: out_data 1,2,3,4 on consecutive cycles starting one cycle later; in_ready stays 1.
- Backpressure:
  - Stimulus: out_ready=0, feed 4'h5 then 4'h6.
  - Required: after the second accept, in_ready=0 and out_data holds 4'h5.
  - Required: in_valid with 4'h7 is not accepted.
  - Stimulus: raise out_ready for 3 cycles.
  - Required: outputs 5,6,7, with 7 accepted once in_ready returns to 1.
- Simultaneous in/out in BUSY:
  - Stimulus: main=4'h8, in_valid=1 with 4'h9, out_ready=1.
  - Required: 8 consumed, next out_data=4'h9, state BUSY, in_ready=1.
- Mid-operation reset:
  - Stimulus: reach FULL (4'hB, 4'hC), assert reset asynchronously between edges.
  - Required: out_valid=0 and in_ready=1 immediately without a clock edge; 4'hB and 4'hC never appear after release.
- Flush (with SKID_BUFFER_FLUSH_EN):
  - Stimulus: in FULL, assert flush=1 with in_valid=1 and 4'hD.
  - Required: next cycle out_valid=0 and in_ready=1; 4'hD is not captured.
